// File: rtl/alarm_input_pio.sv
// Avalon-MM pushbutton/switch input port: sync, debounce, edge capture, irq.
`timescale 1ns/1ps
module alarm_input_pio #(
    parameter int   WIDTH           = 4,
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter int   EDGE_TYPE       = 1,
    parameter logic RESET_LEVEL     = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIDTH-1:0] IDLE = {WIDTH{RESET_LEVEL}};

    logic [WIDTH-1:0] meta;
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] deb_next;
    logic [WIDTH-1:0] deb_prev;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edges;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] clr;
    logic             wr_en;

    assign wr_en = chipselect & ~write_n;
    assign wdata = writedata[WIDTH-1:0];
    assign clr   = (wr_en && address == 2'd3) ? wdata : '0;

    // deb_prev also resets to the idle level so release makes no edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta     <= IDLE;
            sync     <= IDLE;
            deb      <= IDLE;
            deb_prev <= IDLE;
        end else begin
            meta     <= in_port;
            sync     <= meta;
            deb      <= deb_next;
            deb_prev <= deb;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_deb
        logic [CW-1:0] cnt;
        logic          diff;
        logic          done;

        assign diff = sync[i] ^ deb[i];
        assign done = diff && (cnt == CNT_MAX);
        assign deb_next[i] = done ? sync[i] : deb[i];

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt <= '0;
            end else if (!diff || done) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign rise = deb & ~deb_prev;
    assign fall = ~deb & deb_prev;

    if (EDGE_TYPE == 0) begin : g_rise
        assign edges = rise;
    end else if (EDGE_TYPE == 1) begin : g_fall
        assign edges = fall;
    end else begin : g_any
        assign edges = rise | fall;
    end

    // A new edge on the clearing cycle keeps its capture bit set
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask     <= '0;
            edge_capture <= '0;
            irq          <= 1'b0;
        end else begin
            if (wr_en && address == 2'd2) begin
                irq_mask <= wdata;
            end
            edge_capture <= (edge_capture & ~clr) | edges;
            irq          <= |(edge_capture & irq_mask);
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata[WIDTH-1:0] = deb;
            2'd2:    readdata[WIDTH-1:0] = irq_mask;
            2'd3:    readdata[WIDTH-1:0] = edge_capture;
            default: readdata = '0;
        endcase
    end

endmodule

// File: doc/alarm_input_pio.md
Name: alarm_input_pio

Overview:
- Avalon-MM slave input port for pushbuttons/switches; the read-side counterpart of the LED output port on the same CPU bus.
- Each bit of an asynchronous board input is synchronised and debounced, then edge-detected.
- Edges are latched in a per-bit edge-capture register.
- A level interrupt is raised to the Nios CPU when any captured edge is unmasked.

Parameters:
- WIDTH, 4, number of input bits (1..32).
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before the debounced value changes (>=1).
- EDGE_TYPE, 1, edge to capture: 0 = rising, 1 = falling, 2 = any.
- RESET_LEVEL, 1, idle level loaded into all sync/debounce flops on reset (keys idle high).

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- address  input  2  word address: 0 data, 1 reserved, 2 irq mask, 3 edge capture.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe.
- writedata  input  32  write data.
- in_port  input  WIDTH  raw asynchronous board inputs.
- readdata  output  32  read data.
- irq  output  1  level interrupt request, active high.

Behaviour:
- Reset (async, reset_n=0), all bits:
  - sync stages and debounced value = RESET_LEVEL;
  - debounce counters = 0;
  - irq_mask = 0; edge_capture = 0; irq = 0.
  - Reset mid-debounce or mid-capture discards all state; no edge is generated on reset release.
- Synchroniser: 2-flop per bit, giving sync[i] two clocks after in_port[i].
- Debounce, per bit, independent counter:
  - sync[i] == deb[i]: counter cleared to 0.
  - sync[i] != deb[i]: counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing: deb[i] <= sync[i] and counter <= 0 on the same edge.
  - Any glitch back to deb[i] before then restarts the count from 0.
  - Input-to-deb latency: 2 + DEBOUNCE_CYCLES clocks.
  - Counter width: clog2(DEBOUNCE_CYCLES)+1; no wrap possible.
- Edge detect uses deb_prev (deb delayed one clock). Per bit:
  - rise = deb & ~deb_prev;
  - fall = ~deb & deb_prev;
  - edge = rise, fall or rise|fall per EDGE_TYPE.
- Edge capture:
  - edge[i] sets edge_capture[i], which stays set until cleared.
  - Clear: write to address 3 with writedata[i]=1 clears bit i; bits written 0 are unchanged.
  - Same-cycle set and clear on one bit: set wins, so the bit stays 1.
- Interrupt mask:
  - Write to address 2 loads irq_mask <= writedata[WIDTH-1:0].
  - Read returns the mask zero-extended.
- irq = |(edge_capture & irq_mask), registered.
  - Asserts 1 clock after the capture bit sets or the mask is written.
  - Deasserts 1 clock after the clearing write.
- Reads, combinational (zero wait states, same cycle as address):
  - address 0: deb, zero-extended;
  - address 1: 0;
  - address 2: irq_mask;
  - address 3: edge_capture.
  - Reads have no side effects.
- Writes:
  - Require chipselect=1 and write_n=0.
  - Writes to address 0 and 1 are ignored.
  - Bits writedata[31:WIDTH] are ignored.

Test Plan:
- Reset and idle (WIDTH=4, DEBOUNCE_CYCLES=4): assert reset with in_port=4'hF, release, read addr 0 -> 32'h0000000F; addr 2 and 3 -> 0; irq=0 throughout.
- Debounce with glitch: drive in_port[0]=0 for 2 clocks, then 1, then 0 held.
  - Glitch must not change deb.
  - Held 0: addr 0 reads 32'h0000000E exactly 2+4 clocks after the final transition.
  - edge_capture[0]=1 (EDGE_TYPE=1).
- Interrupt path:
  - Write addr 2 = 32'h1; press bit 0 (hold 0) -> irq rises 1 clock after edge_capture[0] sets.
  - Write addr 3 = 32'h1 -> irq falls next clock; addr 3 reads 0.
- Mask gating: mask=32'h2, press bit 0 -> edge_capture=32'h1, irq stays 0; then write mask=32'h3 -> irq=1 next clock.
- Simultaneous set and clear: time the write of 32'h4 to addr 3 on the same clock as bit 2's debounced falling edge -> edge_capture[2] remains 1.
- EDGE_TYPE=2 run: press and release bit 3, clearing between -> capture sets on both the falling and the rising debounced edges.
- Reset mid-operation: reset asserted mid-debounce with capture bits set -> all captures and irq 0, no post-reset edge.
